agent_step_ctrl: RTL and testbench

AGENT_STEP_CTRL -- requirements
Module: agent_step_ctrl

---
 rtl/agent_step_ctrl.sv | 132 +++++++++++++
 tb/tb_agent_step_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/agent_step_ctrl.sv
// rtl/agent_step_ctrl.sv - episode step sequencer for the Q-learning agent datapath
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   start, stop       begin episode (IDLE only) / abort episode (any busy state)
//   mode              1 = exploit-only, 0 = training (epsilon-greedy)
//   epsilon           exploration threshold compared against the LFSR
//   max_step          steps per episode, captured on start
//   rew_valid         environment reward valid
//   A_sel             1 = greedy action, 0 = random action
//   agent_en          agent datapath advance enable (FETCH, DECIDE)
//   act_valid         one-cycle action-valid pulse (DECIDE)
//   q_wr_en           one-cycle Q-table write pulse (UPDATE)
//   busy              high outside IDLE
//   done              one-cycle episode-complete pulse
//   step_cnt          completed steps in the current episode

module agent_step_ctrl #(
   parameter int STEP_WIDTH = 16,
   parameter int EPS_WIDTH  = 8,
   parameter int FETCH_LAT  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  mode,
   input  logic [EPS_WIDTH-1:0]  epsilon,
   input  logic [STEP_WIDTH-1:0] max_step,
   input  logic                  rew_valid,
   output logic                  A_sel,
   output logic                  agent_en,
   output logic                  act_valid,
   output logic                  q_wr_en,
   output logic                  busy,
   output logic                  done,
   output logic [STEP_WIDTH-1:0] step_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECIDE,
      WAIT_R,
      UPDATE,
      DONE
   } state_t;

   localparam int WAIT_W = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_LAT - 1);

   state_t                  state;
   state_t                  next_state;
   logic [WAIT_W-1:0]       wait_cnt;
   logic [EPS_WIDTH-1:0]    lfsr;
   logic                    lfsr_fb;
   logic [STEP_WIDTH-1:0]   max_lat;
   logic [STEP_WIDTH-1:0]   step_inc;

   // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
   assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign step_inc = step_cnt + STEP_WIDTH'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = (max_step != '0) ? FETCH : DONE;
         FETCH:   if (wait_cnt == WAIT_LAST) next_state = DECIDE;
         DECIDE:  next_state = WAIT_R;
         WAIT_R:  if (rew_valid) next_state = UPDATE;
         UPDATE:  next_state = (step_inc == max_lat) ? DONE : FETCH;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      // stop overrides every busy-state transition, including a coincident reward
      if (stop && (state != IDLE)) begin
         next_state = IDLE;
      end
   end

   // Outputs are registered from next_state so they line up with the state
   // they describe while still coming straight out of flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr      <= 8'hA5;
         wait_cnt  <= '0;
         max_lat   <= '0;
         step_cnt  <= '0;
         A_sel     <= 1'b0;
         agent_en  <= 1'b0;
         act_valid <= 1'b0;
         q_wr_en   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         lfsr <= {lfsr[6:0], lfsr_fb};

         if ((state == FETCH) && (next_state == FETCH)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end else begin
            wait_cnt <= '0;
         end

         if ((state == IDLE) && start) begin
            max_lat  <= max_step;
            step_cnt <= '0;
         end else if ((state == UPDATE) && (next_state != IDLE)) begin
            // an aborted UPDATE does not count as a completed step
            step_cnt <= step_inc;
         end

         if ((next_state == DECIDE) && (state != DECIDE)) begin
            A_sel <= mode | (lfsr >= epsilon);
         end

         busy      <= (next_state != IDLE);
         agent_en  <= (next_state == FETCH) || (next_state == DECIDE);
         act_valid <= (next_state == DECIDE);
         q_wr_en   <= (next_state == UPDATE);
         done      <= (next_state == DONE);
      end
   end

endmodule

// File: tb/tb_agent_step_ctrl.sv
// tb/tb_agent_step_ctrl.sv - self-checking bench for agent_step_ctrl

module tb_agent_step_ctrl;

   localparam int STEP_WIDTH = 16;
   localparam int EPS_WIDTH  = 8;
   localparam int FETCH_LAT  = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic                  stop;
   logic                  mode;
   logic [EPS_WIDTH-1:0]  epsilon;
   logic [STEP_WIDTH-1:0] max_step;
   logic                  rew_valid;
   logic                  A_sel;
   logic                  agent_en;
   logic                  act_valid;
   logic                  q_wr_en;
   logic                  busy;
   logic                  done;
   logic [STEP_WIDTH-1:0] step_cnt;

   int checks = 0;
   int errors = 0;
   int act_n  = 0;
   int wr_n   = 0;
   int done_n = 0;

   // scoreboards: A_sel per act_valid (2 = use LFSR model), step_cnt per q_wr_en / done
   int sel_q[$];
   int upd_q[$];
   int done_q[$];

   logic [7:0] m_lfsr;
   logic [7:0] m_prev;

   always #5 clk = ~clk;

   agent_step_ctrl #(
      .STEP_WIDTH(STEP_WIDTH),
      .EPS_WIDTH (EPS_WIDTH),
      .FETCH_LAT (FETCH_LAT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .mode     (mode),
      .epsilon  (epsilon),
      .max_step (max_step),
      .rew_valid(rew_valid),
      .A_sel    (A_sel),
      .agent_en (agent_en),
      .act_valid(act_valid),
      .q_wr_en  (q_wr_en),
      .busy     (busy),
      .done     (done),
      .step_cnt (step_cnt)
   );

   // reference LFSR; m_prev is the value the DUT sampled at the most recent edge
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_lfsr <= 8'hA5;
         m_prev <= 8'hA5;
      end else begin
         m_prev <= m_lfsr;
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (act_valid) begin
            int e;
            act_n++;
            check("act_expected", 32'(sel_q.size() != 0), 1);
            if (sel_q.size() != 0) begin
               e = sel_q.pop_front();
               if (e == 2) e = int'(mode || (m_prev >= epsilon));
               check("A_sel", 32'(A_sel), e);
            end
         end
         if (q_wr_en) begin
            wr_n++;
            check("wr_expected", 32'(upd_q.size() != 0), 1);
            if (upd_q.size() != 0) check("upd_step_cnt", 32'(step_cnt), upd_q.pop_front());
         end
         if (done) begin
            done_n++;
            check("done_expected", 32'(done_q.size() != 0), 1);
            if (done_q.size() != 0) check("done_step_cnt", 32'(step_cnt), done_q.pop_front());
         end
      end
   end

   // k = index of the cycle after the start-sampling edge in which act_valid is seen
   task automatic wait_act(output int k);
      k = 1;
      while (!act_valid && k < 20) begin
         tick();
         k++;
      end
      check("act_seen", 32'(act_valid), 1);
   endtask

   task automatic run_episode(input int ms, input bit md, input logic [7:0] eps);
      int k;
      int a0 = act_n;
      int w0 = wr_n;
      int d0 = done_n;
      mode     = md;
      epsilon  = eps;
      max_step = ms[STEP_WIDTH-1:0];
      for (int i = 0; i < ms; i++) begin
         sel_q.push_back((md || eps == 8'h00) ? 1 : 2);
         upd_q.push_back(i);
      end
      done_q.push_back(ms);
      start = 1'b1;
      tick();
      start    = 1'b0;
      max_step = '1;
      for (int s = 0; s < ms; s++) begin
         wait_act(k);
         if (s == 0) check("first_act_latency", k, FETCH_LAT + 1);
         tick();
         if (s == 0) start = 1'b1;
         tick();
         start     = 1'b0;
         rew_valid = 1'b1;
         tick();
         rew_valid = 1'b0;
         check("q_wr_en_after_rew", 32'(q_wr_en), 1);
      end
      tick();
      check("ep_done", 32'(done), 1);
      tick();
      check("ep_idle", 32'(busy), 0);
      check("ep_final_cnt", 32'(step_cnt), ms);
      check("ep_act_count", act_n - a0, ms);
      check("ep_wr_count", wr_n - w0, ms);
      check("ep_done_count", done_n - d0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int a0;
      int w0;
      int d0;
      rst       = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      mode      = 1'b0;
      epsilon   = '0;
      max_step  = '0;
      rew_valid = 1'b0;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_agent_en", 32'(agent_en), 0);
      check("rst_act_valid", 32'(act_valid), 0);
      check("rst_q_wr_en", 32'(q_wr_en), 0);
      check("rst_done", 32'(done), 0);
      check("rst_step_cnt", 32'(step_cnt), 0);
      check("rst_A_sel", 32'(A_sel), 0);
      rst = 1'b1;
      tick();

      run_episode(3, 1'b1, 8'h00);
      run_episode(4, 1'b0, 8'h00);
      run_episode(6, 1'b0, 8'hFF);
      run_episode(6, 1'b0, 8'h80);

      // zero-length episode
      a0 = act_n;
      done_q.push_back(0);
      max_step = '0;
      start    = 1'b1;
      tick();
      start = 1'b0;
      check("zero_done", 32'(done), 1);
      check("zero_step_cnt", 32'(step_cnt), 0);
      tick();
      check("zero_idle", 32'(busy), 0);
      check("zero_no_act", act_n - a0, 0);

      // stop with coincident reward in the second WAIT_R
      w0 = wr_n;
      d0 = done_n;
      mode     = 1'b1;
      epsilon  = '0;
      max_step = 16'd3;
      sel_q.push_back(1);
      sel_q.push_back(1);
      upd_q.push_back(0);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_act(k);
      tick();
      tick();
      rew_valid = 1'b1;
      tick();
      rew_valid = 1'b0;
      check("stop_first_wr", 32'(q_wr_en), 1);
      wait_act(k);
      tick();
      stop      = 1'b1;
      rew_valid = 1'b1;
      tick();
      stop      = 1'b0;
      rew_valid = 1'b0;
      check("stop_busy", 32'(busy), 0);
      check("stop_q_wr_en", 32'(q_wr_en), 0);
      check("stop_done", 32'(done), 0);
      check("stop_step_cnt", 32'(step_cnt), 1);
      repeat (3) tick();
      check("stop_wr_count", wr_n - w0, 1);
      check("stop_done_count", done_n - d0, 0);
      run_episode(2, 1'b1, 8'h00);

      // asynchronous reset during WAIT_R
      mode     = 1'b1;
      max_step = 16'd5;
      sel_q.push_back(1);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_act(k);
      tick();
      check("pre_rst_busy", 32'(busy), 1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_A_sel", 32'(A_sel), 0);
      check("arst_agent_en", 32'(agent_en), 0);
      check("arst_act_valid", 32'(act_valid), 0);
      check("arst_q_wr_en", 32'(q_wr_en), 0);
      check("arst_done", 32'(done), 0);
      check("arst_step_cnt", 32'(step_cnt), 0);
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_idle", 32'(busy), 0);
      run_episode(2, 1'b0, 8'h40);

      check("sel_q_drained", sel_q.size(), 0);
      check("upd_q_drained", upd_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
